fir_coef_sequencer: RTL and testbench

FIR_COEF_SEQUENCER -- requirements
Module: fir_coef_sequencer

---
 rtl/fir_ctrl_pkg.sv | 23 ++
 rtl/fir_coef_pacer.sv | 31 +++
 rtl/fir_coef_sequencer.sv | 156 +++++++++++++++
 tb/tb_fir_coef_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared types and widths for the FIR coefficient load controller.
package fir_ctrl_pkg;

  localparam int COEF_ADDR_W = 9;
  localparam int COEF_W      = 16;
  localparam int SEL_W       = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT_DATA,
    ST_WRITE,
    ST_PACE,
    ST_NEXT_FILTER,
    ST_FINISH
  } state_t;

  typedef struct packed {
    logic [COEF_W/2-1:0] msb;
    logic [COEF_W/2-1:0] lsb;
  } coef_word_t;

endpackage

// File: rtl/fir_coef_pacer.sv
// Write-spacing down-counter: start loads the PACE length, expire flags its final clock.
// Latency: expire rises WR_SPACING-2 clocks after start (minimum 1).
// Backpressure: none; start always reloads, counter idles at zero.
module fir_coef_pacer #(
  parameter int WR_SPACING = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic expire
);

  // Counting starts on the write strobe; the mandatory WAIT_DATA clock completes the spacing.
  localparam int PACE_CLKS = (WR_SPACING > 3) ? WR_SPACING - 2 : 1;
  localparam int CNT_W     = $clog2(PACE_CLKS + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CNT_W'(PACE_CLKS);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/fir_coef_sequencer.sv
// Loads host coefficient words into TAPS_PER_FILTER RAMs with paced write strobes.
// Latency: one word per WR_SPACING clocks minimum; done pulses two clocks after the last PACE.
// Backpressure: host_ready only in WAIT_DATA; optional checksum via FIR_COEF_CHECKSUM_EN.
module fir_coef_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int TAPS_PER_FILTER = 4,
  parameter int WR_SPACING      = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_start,
  input  logic                   load_abort,
  input  logic [COEF_ADDR_W-1:0] coefs_per_tap,
  input  logic                   audio_en_in,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic [COEF_W-1:0]      host_data,
  output logic                   audio_en,
  output logic                   coef_addr_rst,
  output logic                   coefficient_wr_en,
  output logic [SEL_W-1:0]       coef_select,
  output logic [7:0]             coef_wr_msb_data,
  output logic [7:0]             coef_wr_lsb_data,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [COEF_W-1:0]      checksum
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(TAPS_PER_FILTER - 1);

  state_t                 state, state_nxt;
  logic [SEL_W-1:0]       sel_nxt;
  logic [COEF_ADDR_W-1:0] word_cnt, word_cnt_nxt;
  logic [COEF_ADDR_W-1:0] cpt, cpt_nxt;
  logic                   error_q, error_nxt;
  logic                   latch_word;
  logic                   pace_start, pace_expire;
  coef_word_t             word_q;

  fir_coef_pacer #(
    .WR_SPACING(WR_SPACING)
  ) u_pacer (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (pace_start),
    .expire (pace_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      coef_select <= '0;
      word_cnt    <= '0;
      cpt         <= '0;
      error_q     <= 1'b0;
      word_q      <= '0;
    end else begin
      state       <= state_nxt;
      coef_select <= sel_nxt;
      word_cnt    <= word_cnt_nxt;
      cpt         <= cpt_nxt;
      error_q     <= error_nxt;
      if (latch_word) begin
        word_q <= coef_word_t'(host_data);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    sel_nxt      = coef_select;
    word_cnt_nxt = word_cnt;
    cpt_nxt      = cpt;
    error_nxt    = 1'b0;
    latch_word   = 1'b0;
    pace_start   = (state == ST_WRITE);

    // Abort outranks everything once a load is running; a strobe already on the wire completes.
    if (state != ST_IDLE && load_abort) begin
      state_nxt = ST_IDLE;
      error_nxt = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (load_start) begin
            if (coefs_per_tap != '0) begin
              state_nxt    = ST_CLEAR;
              sel_nxt      = '0;
              word_cnt_nxt = '0;
              cpt_nxt      = coefs_per_tap;
            end else begin
              error_nxt = 1'b1;
            end
          end
        end
        ST_CLEAR:     state_nxt = ST_WAIT_DATA;
        ST_WAIT_DATA: begin
          if (host_valid) begin
            latch_word = 1'b1;
            state_nxt  = ST_WRITE;
          end
        end
        ST_WRITE:     state_nxt = ST_PACE;
        ST_PACE: begin
          if (pace_expire) begin
            word_cnt_nxt = word_cnt + 1'b1;
            state_nxt    = (word_cnt_nxt == cpt) ? ST_NEXT_FILTER : ST_WAIT_DATA;
          end
        end
        ST_NEXT_FILTER: begin
          if (coef_select == LAST_SEL) begin
            state_nxt = ST_FINISH;
          end else begin
            sel_nxt      = coef_select + 1'b1;
            word_cnt_nxt = '0;
            state_nxt    = ST_CLEAR;
          end
        end
        ST_FINISH:    state_nxt = ST_IDLE;
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  assign busy              = (state != ST_IDLE);
  assign host_ready        = (state == ST_WAIT_DATA);
  assign coef_addr_rst     = (state == ST_CLEAR);
  assign coefficient_wr_en = (state == ST_WRITE);
  assign done              = (state == ST_FINISH);
  assign error             = error_q;
  assign coef_wr_msb_data  = word_q.msb;
  assign coef_wr_lsb_data  = word_q.lsb;
  // reset_n in the gate keeps the FIR datapath disabled while reset is held.
  assign audio_en          = audio_en_in & ~busy & reset_n;

`ifdef FIR_COEF_CHECKSUM_EN
  logic [COEF_W-1:0] sum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if (state == ST_IDLE && load_start) begin
      sum_q <= '0;
    end else if (state == ST_WRITE) begin
      sum_q <= sum_q + {word_q.msb, word_q.lsb};
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_fir_coef_sequencer.sv
// Directed bench for fir_coef_sequencer (TAPS_PER_FILTER=4, WR_SPACING=5).
module tb_fir_coef_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, load_start, load_abort;
  logic [8:0]  coefs_per_tap;
  logic        audio_en_in, host_valid, host_ready;
  logic [15:0] host_data;
  logic        audio_en, coef_addr_rst, coefficient_wr_en;
  logic [5:0]  coef_select;
  logic [7:0]  coef_wr_msb_data, coef_wr_lsb_data;
  logic        busy, done, error;
  logic [15:0] checksum;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fir_coef_sequencer #(
    .TAPS_PER_FILTER(4),
    .WR_SPACING     (5)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .load_start       (load_start),
    .load_abort       (load_abort),
    .coefs_per_tap    (coefs_per_tap),
    .audio_en_in      (audio_en_in),
    .host_valid       (host_valid),
    .host_ready       (host_ready),
    .host_data        (host_data),
    .audio_en         (audio_en),
    .coef_addr_rst    (coef_addr_rst),
    .coefficient_wr_en(coefficient_wr_en),
    .coef_select      (coef_select),
    .coef_wr_msb_data (coef_wr_msb_data),
    .coef_wr_lsb_data (coef_wr_lsb_data),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .checksum         (checksum)
  );

  // Observation log, sampled on the falling edge
  int          cyc = 0;
  int          wr_cyc[$];
  logic [5:0]  wr_sel[$];
  logic [15:0] wr_word[$];
  int          rst_cnt = 0, done_cnt = 0, err_cnt = 0, ready_bad = 0, done_cyc = -1;
  logic [15:0] feed_q[$];

  always @(negedge clk) begin
    cyc++;
    if (coefficient_wr_en) begin
      wr_cyc.push_back(cyc);
      wr_sel.push_back(coef_select);
      wr_word.push_back({coef_wr_msb_data, coef_wr_lsb_data});
    end
    if (coef_addr_rst) rst_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (error) err_cnt++;
    if (host_ready && (coefficient_wr_en || coef_addr_rst || !busy)) ready_bad++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [8:0] cpt);
    load_start = 1'b1; coefs_per_tap = cpt;
    tick();
    load_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    for (int i = 0; i < budget && busy; i++) tick();
    ok = !busy;
  endtask

  task automatic wait_writes(input int target, input int budget, output bit ok);
    for (int i = 0; i < budget && wr_cyc.size() < target; i++) tick();
    ok = (wr_cyc.size() >= target);
  endtask

  task automatic feed(input int gap, output bit ok, output int drops);
    ok = 1'b1; drops = 0;
    while (feed_q.size() > 0) begin
      for (int i = 0; i < 200 && !host_ready; i++) tick();
      if (!host_ready) begin ok = 1'b0; return; end
      for (int i = 0; i < gap; i++) begin tick(); if (!host_ready) drops++; end
      host_valid = 1'b1; host_data = feed_q.pop_front();
      tick();
      host_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b1; load_start = 0; load_abort = 0; coefs_per_tap = 9'd3;
    audio_en_in = 1'b1; host_valid = 0; host_data = '0;
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_checks++; if ({done, error} !== 2'b00) begin n_fail++; $display("FAIL rst_pulses got %b want 00", {done, error}); end
    n_checks++; if ({host_ready, coefficient_wr_en, coef_addr_rst} !== 3'b000) begin n_fail++; $display("FAIL rst_strobes got %b want 000", {host_ready, coefficient_wr_en, coef_addr_rst}); end
    n_checks++; if (coef_select !== 6'd0) begin n_fail++; $display("FAIL rst_sel got %0d want 0", coef_select); end
    n_checks++; if ({coef_wr_msb_data, coef_wr_lsb_data} !== 16'h0000) begin n_fail++; $display("FAIL rst_data got %h want 0000", {coef_wr_msb_data, coef_wr_lsb_data}); end
    n_checks++; if (checksum !== 16'h0000) begin n_fail++; $display("FAIL rst_checksum got %h want 0000", checksum); end
    n_checks++; if (audio_en !== 1'b0) begin n_fail++; $display("FAIL rst_audio_en got %b want 0", audio_en); end
    tick(2);
    reset_n = 1'b1;
    tick();
    n_checks++; if (audio_en !== 1'b1) begin n_fail++; $display("FAIL idle_audio_en got %b want 1", audio_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_full_load;
    int w0, r0, d0, mn, mx, bad_sel, sp;
    bit ok;
    logic [15:0] exp_sum;
    w0 = wr_cyc.size(); r0 = rst_cnt; d0 = done_cnt;
    host_valid = 1'b1; host_data = 16'h0101;
    pulse_start(9'd3);
    coefs_per_tap = 9'd7;
    n_checks++; if ({busy, audio_en, coef_addr_rst} !== 3'b101) begin n_fail++; $display("FAIL load_status got %b want 101", {busy, audio_en, coef_addr_rst}); end
    wait_idle(400, ok);
    host_valid = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL load_timeout busy=%b want 0", busy); end
    n_checks++; if (wr_cyc.size() - w0 !== 12) begin n_fail++; $display("FAIL load_writes got %0d want 12", wr_cyc.size() - w0); end
    n_checks++; if (rst_cnt - r0 !== 4) begin n_fail++; $display("FAIL load_addr_rst got %0d want 4", rst_cnt - r0); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL load_done got %0d want 1", done_cnt - d0); end
    if (wr_cyc.size() >= w0 + 12) begin
      mn = 1000; mx = 0; bad_sel = 0;
      for (int k = 0; k < 12; k++) begin
        if (wr_sel[w0+k] !== 6'(k / 3)) bad_sel++;
        if (k < 11 && (k % 3) != 2) begin
          sp = wr_cyc[w0+k+1] - wr_cyc[w0+k];
          if (sp < mn) mn = sp;
          if (sp > mx) mx = sp;
        end
      end
      n_checks++; if (mn !== 5 || mx !== 5) begin n_fail++; $display("FAIL load_spacing got %0d..%0d want 5..5", mn, mx); end
      n_checks++; if (bad_sel !== 0) begin n_fail++; $display("FAIL load_order got %0d misplaced writes want 0", bad_sel); end
      n_checks++; if (done_cyc - wr_cyc[w0+11] !== 5) begin n_fail++; $display("FAIL load_done_time got %0d want 5", done_cyc - wr_cyc[w0+11]); end
    end
`ifdef FIR_COEF_CHECKSUM_EN
    exp_sum = 16'h0C0C;
`else
    exp_sum = 16'h0000;
`endif
    n_checks++; if (checksum !== exp_sum) begin n_fail++; $display("FAIL load_checksum got %h want %h", checksum, exp_sum); end
  endtask

  task automatic test_checksum;
    int w0, drops;
    bit ok;
    logic [15:0] exp_sum;
    w0 = wr_cyc.size();
    feed_q = {16'h1234, 16'hFFFF, 16'h0001};
    for (int i = 0; i < 9; i++) feed_q.push_back(16'h0000);
    pulse_start(9'd3);
    feed(0, ok, drops);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL cks_feed_timeout ready=%b want 1", host_ready); end
    wait_idle(100, ok);
    n_checks++; if (wr_cyc.size() - w0 !== 12) begin n_fail++; $display("FAIL cks_writes got %0d want 12", wr_cyc.size() - w0); end
    if (wr_cyc.size() >= w0 + 3) begin
      n_checks++; if (wr_word[w0] !== 16'h1234) begin n_fail++; $display("FAIL cks_word0 got %h want 1234", wr_word[w0]); end
      n_checks++; if (wr_word[w0+1] !== 16'hFFFF) begin n_fail++; $display("FAIL cks_word1 got %h want ffff", wr_word[w0+1]); end
      n_checks++; if (wr_word[w0+2] !== 16'h0001) begin n_fail++; $display("FAIL cks_word2 got %h want 0001", wr_word[w0+2]); end
    end
`ifdef FIR_COEF_CHECKSUM_EN
    exp_sum = 16'h1234;
`else
    exp_sum = 16'h0000;
`endif
    n_checks++; if (checksum !== exp_sum) begin n_fail++; $display("FAIL cks_value got %h want %h", checksum, exp_sum); end
  endtask

  task automatic test_abort;
    int w0, e0;
    bit ok;
    w0 = wr_cyc.size();
    host_valid = 1'b1; host_data = 16'h5A5A; audio_en_in = 1'b1;
    pulse_start(9'd3);
    wait_writes(w0 + 5, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_reach5 got %0d writes want 5", wr_cyc.size() - w0); end
    tick();
    e0 = err_cnt;
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    n_checks++; if ({error, busy, audio_en} !== 3'b101) begin n_fail++; $display("FAIL abort_status got %b want 101", {error, busy, audio_en}); end
    tick(20);
    host_valid = 1'b0;
    n_checks++; if (wr_cyc.size() - w0 !== 5) begin n_fail++; $display("FAIL abort_writes got %0d want 5", wr_cyc.size() - w0); end
    n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL abort_err_pulses got %0d want 1", err_cnt - e0); end
    audio_en_in = 1'b0;
    #1;
    n_checks++; if (audio_en !== 1'b0) begin n_fail++; $display("FAIL abort_audio_follow got %b want 0", audio_en); end
    audio_en_in = 1'b1;
  endtask

  task automatic test_zero_count;
    int w0, e0, r0;
    w0 = wr_cyc.size(); e0 = err_cnt; r0 = rst_cnt;
    host_valid = 1'b1;
    pulse_start(9'd0);
    n_checks++; if ({error, busy} !== 2'b10) begin n_fail++; $display("FAIL zero_status got %b want 10", {error, busy}); end
    tick(6);
    host_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %b want 0", busy); end
    n_checks++; if (wr_cyc.size() - w0 !== 0 || rst_cnt - r0 !== 0) begin n_fail++; $display("FAIL zero_strobes got %0d/%0d want 0/0", wr_cyc.size() - w0, rst_cnt - r0); end
    n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL zero_err_pulses got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_start_abort_same;
    int w0;
    w0 = wr_cyc.size();
    load_start = 1'b1; load_abort = 1'b1; coefs_per_tap = 9'd2;
    tick();
    load_start = 1'b0; load_abort = 1'b0;
    n_checks++; if ({busy, error} !== 2'b10) begin n_fail++; $display("FAIL same_idle got %b want 10", {busy, error}); end
    tick(2);
    load_start = 1'b1; load_abort = 1'b1;
    tick();
    load_start = 1'b0; load_abort = 1'b0;
    n_checks++; if ({busy, error} !== 2'b01) begin n_fail++; $display("FAIL same_busy got %b want 01", {busy, error}); end
    tick(3);
    n_checks++; if (wr_cyc.size() - w0 !== 0) begin n_fail++; $display("FAIL same_writes got %0d want 0", wr_cyc.size() - w0); end
  endtask

  task automatic test_gapped;
    int w0, rb0, drops, mn, bad_word;
    bit ok;
    w0 = wr_cyc.size(); rb0 = ready_bad;
    for (int i = 0; i < 8; i++) feed_q.push_back(16'h0100 + 16'(i));
    pulse_start(9'd2);
    feed(20, ok, drops);
    n_checks++; if (!ok || drops !== 0) begin n_fail++; $display("FAIL gap_ready ok=%b drops=%0d want 1/0", ok, drops); end
    wait_idle(100, ok);
    n_checks++; if (wr_cyc.size() - w0 !== 8) begin n_fail++; $display("FAIL gap_writes got %0d want 8", wr_cyc.size() - w0); end
    if (wr_cyc.size() >= w0 + 8) begin
      mn = 1000; bad_word = 0;
      for (int k = 0; k < 8; k++) begin
        if (wr_word[w0+k] !== 16'h0100 + 16'(k)) bad_word++;
        if (k < 7 && wr_cyc[w0+k+1] - wr_cyc[w0+k] < mn) mn = wr_cyc[w0+k+1] - wr_cyc[w0+k];
      end
      n_checks++; if (mn < 20) begin n_fail++; $display("FAIL gap_spacing got %0d want >=20", mn); end
      n_checks++; if (bad_word !== 0) begin n_fail++; $display("FAIL gap_data got %0d wrong words want 0", bad_word); end
    end
    n_checks++; if (ready_bad - rb0 !== 0) begin n_fail++; $display("FAIL gap_ready_state got %0d stray cycles want 0", ready_bad - rb0); end
  endtask

  task automatic test_reset_mid;
    int w0, w1, r1;
    bit ok;
    w0 = wr_cyc.size();
    host_valid = 1'b1; host_data = 16'hABCD; audio_en_in = 1'b1;
    pulse_start(9'd3);
    wait_writes(w0 + 4, 200, ok);
    tick(2);
    n_checks++; if ({busy, coef_select} !== {1'b1, 6'd1}) begin n_fail++; $display("FAIL mid_pre got busy=%b sel=%0d want 1/1", busy, coef_select); end
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if ({busy, done, error, host_ready, coefficient_wr_en, coef_addr_rst} !== 6'b0) begin n_fail++; $display("FAIL mid_strobes got %b want 000000", {busy, done, error, host_ready, coefficient_wr_en, coef_addr_rst}); end
    n_checks++; if (coef_select !== 6'd0) begin n_fail++; $display("FAIL mid_sel got %0d want 0", coef_select); end
    n_checks++; if ({coef_wr_msb_data, coef_wr_lsb_data, checksum} !== 32'h0) begin n_fail++; $display("FAIL mid_data got %h want 0", {coef_wr_msb_data, coef_wr_lsb_data, checksum}); end
    n_checks++; if (audio_en !== 1'b0) begin n_fail++; $display("FAIL mid_audio_en got %b want 0", audio_en); end
    tick();
    reset_n = 1'b1;
    tick(8);
    n_checks++; if (busy !== 1'b0 || wr_cyc.size() - w0 !== 4) begin n_fail++; $display("FAIL mid_no_resume busy=%b writes=%0d want 0/4", busy, wr_cyc.size() - w0); end
    w1 = wr_cyc.size(); r1 = rst_cnt;
    pulse_start(9'd1);
    wait_idle(200, ok);
    host_valid = 1'b0;
    n_checks++; if (wr_cyc.size() - w1 !== 4 || rst_cnt - r1 !== 4) begin n_fail++; $display("FAIL reload_counts got %0d/%0d want 4/4", wr_cyc.size() - w1, rst_cnt - r1); end
    if (wr_cyc.size() > w1) begin
      n_checks++; if (wr_sel[w1] !== 6'd0) begin n_fail++; $display("FAIL reload_first_sel got %0d want 0", wr_sel[w1]); end
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_checksum();
    test_abort();
    test_zero_count();
    test_start_abort_same();
    test_gapped();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d, bench did not complete", cyc);
    $fatal(1, "watchdog");
  end

endmodule
